// File: rtl/ctrl_pkg.sv
// Shared encodings for the ID stage: ALU/branch ops,
// RV32I opcodes and the registered control bundle.
package ctrl_pkg;

  localparam logic [3:0] ALU_ADD   = 4'h0;
  localparam logic [3:0] ALU_SUB   = 4'h1;
  localparam logic [3:0] ALU_AND   = 4'h2;
  localparam logic [3:0] ALU_OR    = 4'h3;
  localparam logic [3:0] ALU_XOR   = 4'h4;
  localparam logic [3:0] ALU_SLL   = 4'h5;
  localparam logic [3:0] ALU_SRL   = 4'h6;
  localparam logic [3:0] ALU_SRA   = 4'h7;
  localparam logic [3:0] ALU_SLT   = 4'h8;
  localparam logic [3:0] ALU_SLTU  = 4'h9;
  localparam logic [3:0] ALU_LUI   = 4'hA;
  localparam logic [3:0] ALU_AUIPC = 4'hB;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLT  = 3'd3;
  localparam logic [2:0] BR_BGE  = 3'd4;
  localparam logic [2:0] BR_BLTU = 3'd5;
  localparam logic [2:0] BR_BGEU = 3'd6;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic [2:0]  br_op;
    logic        alu_src;
    logic        sftmd;
    logic        jal;
    logic        jalr;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        io_read;
    logic        io_write;
    logic        mem_to_reg;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] instr;
    logic        illegal;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational RV32I decoder producing the ctrl_t
// bundle plus register-use and MMIO classification.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned IO_BASE_REG = 27,
  parameter logic [31:0] IO_RD_MASK  = 32'h0000_013E,
  parameter logic [31:0] IO_WR_MASK  = 32'h0000_00C0
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic        is_io
);

  logic [6:0] opc;
  logic [6:0] f7;
  logic [2:0] f3;
  logic       io_ok;
  logic       alt;
  logic       bad;
  logic [3:0] f3_op;

  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign alt   = (f7 == 7'h20);
  // imm[11:5] sits in instr[31:25] for both I and S formats
  assign io_ok = (instr[19:15] == 5'(IO_BASE_REG)) && (f7 == 7'd0);

  always_comb begin
    unique case (f3)
      3'b000: f3_op = ALU_ADD;
      3'b001: f3_op = ALU_SLL;
      3'b010: f3_op = ALU_SLT;
      3'b011: f3_op = ALU_SLTU;
      3'b100: f3_op = ALU_XOR;
      3'b101: f3_op = ALU_SRL;
      3'b110: f3_op = ALU_OR;
      3'b111: f3_op = ALU_AND;
    endcase
  end

  always_comb begin
    ctrl     = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    bad      = 1'b0;
    unique case (1'b1)
      opc == OP_REG: begin
        uses_rs1       = 1'b1;
        uses_rs2       = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = f3_op;
        if (alt && f3 == 3'b000) ctrl.alu_op = ALU_SUB;
        else if (alt && f3 == 3'b101) ctrl.alu_op = ALU_SRA;
        else bad = (f7 != 7'd0);
      end
      opc == OP_IMM: begin
        uses_rs1       = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = f3_op;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          ctrl.sftmd = 1'b1;
          if (alt && f3 == 3'b101) ctrl.alu_op = ALU_SRA;
          else bad = (f7 != 7'd0);
        end
      end
      opc == OP_LOAD: begin
        uses_rs1        = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.io_read    = io_ok && IO_RD_MASK[instr[24:20]];
        ctrl.mem_read   = !ctrl.io_read;
        bad             = (f3 != 3'b010);
      end
      opc == OP_STORE: begin
        uses_rs1       = 1'b1;
        uses_rs2       = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.io_write  = io_ok && IO_WR_MASK[instr[11:7]];
        ctrl.mem_write = !ctrl.io_write;
        bad            = (f3 != 3'b010);
      end
      opc == OP_BRANCH: begin
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
        ctrl.alu_op = ALU_SUB;
        case (f3)
          3'b000:  ctrl.br_op = BR_BEQ;
          3'b001:  ctrl.br_op = BR_BNE;
          3'b100:  ctrl.br_op = BR_BLT;
          3'b101:  ctrl.br_op = BR_BGE;
          3'b110:  ctrl.br_op = BR_BLTU;
          3'b111:  ctrl.br_op = BR_BGEU;
          default: begin
            ctrl.br_op = BR_NONE;
            bad        = 1'b1;
          end
        endcase
      end
      opc == OP_JAL: begin
        ctrl.jal       = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      opc == OP_JALR: begin
        uses_rs1       = 1'b1;
        ctrl.jalr      = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        bad            = (f3 != 3'b000);
      end
      opc == OP_LUI: begin
        ctrl.alu_op    = ALU_LUI;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      opc == OP_AUIPC: begin
        ctrl.alu_op    = ALU_AUIPC;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      ctrl         = '0;
      uses_rs1     = 1'b0;
      uses_rs2     = 1'b0;
      ctrl.illegal = 1'b1;
    end
    ctrl.rd    = instr[11:7];
    ctrl.rs1   = instr[19:15];
    ctrl.rs2   = instr[24:20];
    ctrl.instr = instr;
  end

  assign is_io = ctrl.io_read | ctrl.io_write;

endmodule

// File: rtl/id_ctrl_stage.sv
// Registered ID/EX stage: decode, load-use and MMIO
// spacing stalls, flush and sticky illegal flag.
module id_ctrl_stage
  import ctrl_pkg::*;
#(
  parameter int unsigned IO_BASE_REG = 27,
  parameter logic [31:0] IO_RD_MASK  = 32'h0000_013E,
  parameter logic [31:0] IO_WR_MASK  = 32'h0000_00C0,
  parameter int unsigned IO_GAP      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  output logic        if_ready,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [3:0]  ex_alu_op,
  output logic [2:0]  ex_br_op,
  output logic        ex_alu_src,
  output logic        ex_sftmd,
  output logic        ex_jal,
  output logic        ex_jalr,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_io_read,
  output logic        ex_io_write,
  output logic        ex_mem_to_reg,
  output logic [4:0]  ex_rd,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [31:0] ex_instr,
  output logic        ex_illegal,
  output logic        illegal_seen
);

  ctrl_t      dec;
  ctrl_t      ex_q;
  logic       ex_v;
  logic       ill_q;
  logic [3:0] io_cnt;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       is_io;
  logic       adv;
  logic       ex_io;
  logic       load_use;
  logic       io_block;
  logic       stall;

  ctrl_decode #(
    .IO_BASE_REG(IO_BASE_REG),
    .IO_RD_MASK (IO_RD_MASK),
    .IO_WR_MASK (IO_WR_MASK)
  ) u_dec (
    .instr   (if_instr),
    .ctrl    (dec),
    .uses_rs1(uses_rs1),
    .uses_rs2(uses_rs2),
    .is_io   (is_io)
  );

  assign adv   = !ex_v | ex_ready;
  assign ex_io = ex_v & (ex_q.io_read | ex_q.io_write);

  assign load_use = ex_v
                  & (ex_q.mem_read | ex_q.io_read)
                  & (ex_q.rd != 5'd0)
                  & ((uses_rs1 & (if_instr[19:15] == ex_q.rd))
                   | (uses_rs2 & (if_instr[24:20] == ex_q.rd)));

  // An IO op still sitting in EX has not left yet, so the
  // gap has not started counting; hold the next one too.
  assign io_block = is_io & ((io_cnt != 4'd0) | ex_io);
  assign stall    = if_valid & (load_use | io_block);
  assign if_ready = flush | (adv & !stall);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v   <= 1'b0;
      ex_q   <= '0;
      ill_q  <= 1'b0;
      io_cnt <= 4'd0;
    end else begin
      if (flush) begin
        ex_v <= 1'b0;
        ex_q <= '0;
      end else if (adv) begin
        if (if_valid && !stall) begin
          ex_v <= 1'b1;
          ex_q <= dec;
          if (dec.illegal) ill_q <= 1'b1;
        end else begin
          ex_v <= 1'b0;
          ex_q <= '0;
        end
      end
      if (ex_io && ex_ready) io_cnt <= 4'(IO_GAP);
      else if (io_cnt != 4'd0) io_cnt <= io_cnt - 4'd1;
    end
  end

  assign ex_valid      = ex_v;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_br_op      = ex_q.br_op;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_sftmd      = ex_q.sftmd;
  assign ex_jal        = ex_q.jal;
  assign ex_jalr       = ex_q.jalr;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_io_read    = ex_q.io_read;
  assign ex_io_write   = ex_q.io_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_rd         = ex_q.rd;
  assign ex_rs1        = ex_q.rs1;
  assign ex_rs2        = ex_q.rs2;
  assign ex_instr      = ex_q.instr;
  assign ex_illegal    = ex_q.illegal;
  assign illegal_seen  = ill_q;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Bench for id_ctrl_stage: cycle model comparison plus
// directed vectors with literal expectations.
module tb_id_ctrl_stage;

  localparam int unsigned BASE    = 27;
  localparam logic [31:0] RD_MASK = 32'h0000_013E;
  localparam logic [31:0] WR_MASK = 32'h0000_00C0;
  localparam int          GAP     = 2;

  localparam logic [3:0] ALU_TBL [8] =
    '{4'h0, 4'h5, 4'h8, 4'h9, 4'h4, 4'h6, 4'h3, 4'h2};
  localparam logic [2:0] BR_TBL [8] =
    '{3'd1, 3'd2, 3'd0, 3'd0, 3'd3, 3'd4, 3'd5, 3'd6};

  typedef struct packed {
    logic       ill;
    logic [3:0] alu;
    logic [2:0] br;
    logic       src, sft, jal, jalr, rw;
    logic       mr, mw, ior, iow, m2r;
    logic       r1, r2, io;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [3:0]  ex_alu_op;
  logic [2:0]  ex_br_op;
  logic        ex_alu_src, ex_sftmd, ex_jal, ex_jalr;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_io_read, ex_io_write, ex_mem_to_reg;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  logic [31:0] ex_instr;
  logic        ex_illegal;
  logic        illegal_seen;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  id_ctrl_stage #(
    .IO_BASE_REG(BASE),
    .IO_RD_MASK (RD_MASK),
    .IO_WR_MASK (WR_MASK),
    .IO_GAP     (GAP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_ready     (if_ready),
    .flush        (flush),
    .ex_ready     (ex_ready),
    .ex_valid     (ex_valid),
    .ex_alu_op    (ex_alu_op),
    .ex_br_op     (ex_br_op),
    .ex_alu_src   (ex_alu_src),
    .ex_sftmd     (ex_sftmd),
    .ex_jal       (ex_jal),
    .ex_jalr      (ex_jalr),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_io_read   (ex_io_read),
    .ex_io_write  (ex_io_write),
    .ex_mem_to_reg(ex_mem_to_reg),
    .ex_rd        (ex_rd),
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .ex_instr     (ex_instr),
    .ex_illegal   (ex_illegal),
    .illegal_seen (illegal_seen)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode written from the instruction tables
  function automatic exp_t ref_dec(input logic [31:0] i);
    exp_t       e;
    logic       ok;
    logic       io;
    logic [2:0] f3;
    logic [6:0] f7;
    e  = '0;
    ok = 1'b1;
    f3 = i[14:12];
    f7 = i[31:25];
    case (i[6:0])
      7'h33: begin
        e.alu = ALU_TBL[f3]; e.r1 = 1; e.r2 = 1; e.rw = 1;
        if (f7 == 7'h20 && f3 == 3'd0) e.alu = 4'h1;
        else if (f7 == 7'h20 && f3 == 3'd5) e.alu = 4'h7;
        else if (f7 != 7'h00) ok = 0;
      end
      7'h13: begin
        e.alu = ALU_TBL[f3]; e.r1 = 1; e.src = 1; e.rw = 1;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.sft = 1;
          if (f3 == 3'd5 && f7 == 7'h20) e.alu = 4'h7;
          else if (f7 != 7'h00) ok = 0;
        end
      end
      7'h03: begin
        ok = (f3 == 3'd2);
        e.r1 = 1; e.src = 1; e.rw = 1; e.m2r = 1;
        io = (i[19:15] == 5'(BASE)) && (f7 == 0) && RD_MASK[i[24:20]];
        e.ior = io; e.mr = !io;
      end
      7'h23: begin
        ok = (f3 == 3'd2);
        e.r1 = 1; e.r2 = 1; e.src = 1;
        io = (i[19:15] == 5'(BASE)) && (f7 == 0) && WR_MASK[i[11:7]];
        e.iow = io; e.mw = !io;
      end
      7'h63: begin
        e.br = BR_TBL[f3]; ok = (e.br != 0);
        e.alu = 4'h1; e.r1 = 1; e.r2 = 1;
      end
      7'h6F: begin e.jal = 1; e.rw = 1; end
      7'h67: begin
        ok = (f3 == 0); e.jalr = 1; e.rw = 1; e.r1 = 1; e.src = 1;
      end
      7'h37: begin e.alu = 4'hA; e.src = 1; e.rw = 1; end
      7'h17: begin e.alu = 4'hB; e.src = 1; e.rw = 1; end
      default: ok = 0;
    endcase
    if (!ok) begin
      e     = '0;
      e.ill = 1;
    end
    e.io = e.ior | e.iow;
    return e;
  endfunction

  // Model state: EX contents, sticky flag, time of last IO exit
  logic        m_valid;
  exp_t        m_exp;
  logic [31:0] m_instr;
  logic        m_ill;
  int          cyc;
  int          last_leave;

  function automatic logic hazard(input exp_t d, input logic [31:0] ins);
    logic [4:0] rd;
    logic       lu;
    logic       iob;
    rd  = m_instr[11:7];
    lu  = m_valid && (m_exp.mr || m_exp.ior) && rd != 0 &&
          ((d.r1 && ins[19:15] == rd) || (d.r2 && ins[24:20] == rd));
    iob = d.io && ((m_valid && m_exp.io) || (cyc - last_leave) <= GAP);
    return lu || iob;
  endfunction

  function automatic logic m_ready();
    return flush || ((!m_valid || ex_ready) &&
           !(if_valid && hazard(ref_dec(if_instr), if_instr)));
  endfunction

  always @(posedge clk or negedge rst_n) begin : mdl
    exp_t d;
    logic hz;
    logic lv;
    if (!rst_n) begin
      m_valid    = 0;
      m_exp      = '0;
      m_instr    = '0;
      m_ill      = 0;
      cyc        = 0;
      last_leave = -100;
    end else begin
      d  = ref_dec(if_instr);
      hz = hazard(d, if_instr);
      lv = m_valid && ex_ready && m_exp.io;
      if (flush) m_valid = 0;
      else if (!m_valid || ex_ready) begin
        m_valid = if_valid && !hz;
        if (m_valid) begin
          m_exp   = d;
          m_instr = if_instr;
          if (d.ill) m_ill = 1;
        end
      end
      if (lv) last_leave = cyc;
      cyc++;
    end
  end

  always @(negedge clk) begin
    chk("if_ready", 32'(if_ready), 32'(m_ready()));
    chk("ex_valid", 32'(ex_valid), 32'(m_valid));
    chk("illegal_seen", 32'(illegal_seen), 32'(m_ill));
    if (m_valid) begin
      chk("flags",
          32'({ex_illegal, ex_alu_op, ex_br_op, ex_alu_src, ex_sftmd,
               ex_jal, ex_jalr, ex_reg_write, ex_mem_read,
               ex_mem_write, ex_io_read, ex_io_write, ex_mem_to_reg}),
          32'({m_exp.ill, m_exp.alu, m_exp.br, m_exp.src, m_exp.sft,
               m_exp.jal, m_exp.jalr, m_exp.rw, m_exp.mr, m_exp.mw,
               m_exp.ior, m_exp.iow, m_exp.m2r}));
      chk("regs", 32'({ex_rd, ex_rs1, ex_rs2}),
          32'({m_instr[11:7], m_instr[19:15], m_instr[24:20]}));
      chk("instr", ex_instr, m_instr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] ins);
    if_valid = 1'b1;
    if_instr = ins;
  endtask

  task automatic idle(input int n);
    if_valid = 1'b0;
    repeat (n) step();
  endtask

  logic [31:0] mix [20] = '{
    32'h402081B3, 32'h4020D233, 32'h0020A2B3, 32'h0020B333,
    32'hFFF0A393, 32'h0010B413, 32'h4030D493, 32'h00209513,
    32'h123455B7, 32'h00001617, 32'h010000EF, 32'h00008067,
    32'h005DA323, 32'h004DA183, 32'h00018233, 32'h005DA323,
    32'h00512023, 32'h00209463, 32'h0020F463, 32'h7E0080B3
  };

  initial begin
    int   blocked;
    int   n;
    logic r;
    rst_n    = 1'b0;
    if_valid = 1'b0;
    if_instr = '0;
    flush    = 1'b0;
    ex_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", 32'(ex_valid), 0);
    chk("rst_illegal_seen", 32'(illegal_seen), 0);
    chk("rst_if_ready", 32'(if_ready), 1);
    chk("rst_alu_op", 32'(ex_alu_op), 0);
    rst_n = 1'b1;
    step();

    offer(32'h00500093);
    step();
    if_valid = 1'b0;
    chk("addi_valid", 32'(ex_valid), 1);
    chk("addi_alu", 32'(ex_alu_op), 0);
    chk("addi_src", 32'(ex_alu_src), 1);
    chk("addi_rw", 32'(ex_reg_write), 1);
    chk("addi_rd", 32'(ex_rd), 1);
    chk("addi_ill", 32'(ex_illegal), 0);

    offer(32'h00012283);
    step();
    offer(32'h00128333);
    #1;
    chk("lu_hold", 32'(if_ready), 0);
    step();
    chk("lu_bubble", 32'(ex_valid), 0);
    #1;
    chk("lu_release", 32'(if_ready), 1);
    step();
    chk("lu_add_valid", 32'(ex_valid), 1);
    chk("lu_add_rd", 32'(ex_rd), 6);
    idle(2);

    offer(32'h004DA083);
    step();
    chk("io_read", 32'(ex_io_read), 1);
    chk("io_mem_read", 32'(ex_mem_read), 0);
    chk("io_m2r", 32'(ex_mem_to_reg), 1);
    offer(32'h008DA103);
    blocked = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (if_ready) break;
      blocked++;
      step();
    end
    chk("io_gap_hold", blocked, GAP + 1);
    step();
    chk("io2_valid", 32'(ex_valid), 1);
    chk("io2_rd", 32'(ex_rd), 2);
    idle(2);

    offer(32'h0020C463);
    step();
    chk("blt_br", 32'(ex_br_op), 3);
    chk("blt_alu", 32'(ex_alu_op), 1);
    offer(32'h00500093);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    if_valid = 1'b0;
    chk("flush_valid", 32'(ex_valid), 0);
    step();
    chk("flush_dropped", 32'(ex_valid), 0);

    offer(32'hFFFFFFFF);
    step();
    chk("ill_flag", 32'(ex_illegal), 1);
    chk("ill_rw", 32'(ex_reg_write), 0);
    chk("ill_seen", 32'(illegal_seen), 1);
    offer(32'h00500093);
    repeat (10) step();
    if_valid = 1'b0;
    chk("ill_sticky", 32'(illegal_seen), 1);
    rst_n = 1'b0;
    #1;
    chk("ill_cleared", 32'(illegal_seen), 0);
    step();
    rst_n = 1'b1;
    step();

    offer(32'h00500093);
    step();
    ex_ready = 1'b0;
    offer(32'h00700113);
    repeat (3) begin
      #1;
      chk("bp_if_ready", 32'(if_ready), 0);
      chk("bp_hold_rd", 32'(ex_rd), 1);
      step();
    end
    ex_ready = 1'b1;
    #1;
    chk("bp_release", 32'(if_ready), 1);
    step();
    chk("bp_next_rd", 32'(ex_rd), 2);
    chk("bp_next_valid", 32'(ex_valid), 1);
    idle(2);

    offer(32'h00012283);
    step();
    offer(32'h00128333);
    #1;
    chk("rs_stall", 32'(if_ready), 0);
    rst_n = 1'b0;
    #1;
    chk("rs_valid", 32'(ex_valid), 0);
    chk("rs_ready", 32'(if_ready), 1);
    step();
    rst_n = 1'b1;
    step();
    idle(2);

    offer(32'h00500093);
    step();
    ex_ready = 1'b0;
    flush    = 1'b1;
    if_valid = 1'b0;
    #1;
    chk("fl_nr_ready", 32'(if_ready), 1);
    step();
    flush    = 1'b0;
    ex_ready = 1'b1;
    chk("fl_nr_valid", 32'(ex_valid), 0);
    idle(4);

    foreach (mix[k]) begin
      offer(mix[k]);
      n = 0;
      do begin
        @(negedge clk);
        r = if_ready;
        @(posedge clk);
        #1;
        ex_ready = ($urandom_range(0, 3) != 0);
        n++;
      end while (!r && n < 50);
      if (!r) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout: instr %h not taken", mix[k]);
      end
    end
    if_valid = 1'b0;
    ex_ready = 1'b1;
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
